// File: rtl/audio_ser_pkg.sv
// ---------------------------------------------------------------------------
// audio_ser_pkg : shared types and helpers for the audio serializer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package audio_ser_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int UNDERRUN_CNT_W = 16;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_ser_hold_buf.sv
// ---------------------------------------------------------------------------
// audio_ser_hold_buf : one-deep holding register between handshake and shifter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_ser_hold_buf
  import audio_ser_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (pop) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      data_d = push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/audio_serializer_p.sv
// ---------------------------------------------------------------------------
// audio_serializer_p : parametrised valid/ready word-to-serial audio shifter
// Optional underrun counter: AUDIO_SERIALIZER_UNDERRUN_CNT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_serializer_p
  import audio_ser_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BIT_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              audio_enable,
  output logic              audio_data,
  output logic              word_done,
  output logic              underrun
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

  localparam int BIT_W = cnt_w(DATA_W);
  localparam int DIV_W = cnt_w(BIT_DIV);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BIT_DIV - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;

  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_clear;
  logic              done_w;
  logic              under_w;
  logic              head_w;
  logic [DATA_W-1:0] shifted_w;

  assign in_ready     = reset_n & enable & ~buf_full;
  assign buf_push     = in_valid & in_ready;
  assign audio_enable = enable;

  audio_ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (buf_clear),
    .push      (buf_push),
    .pop       (buf_pop),
    .push_data (in_data),
    .full      (buf_full),
    .data      (buf_data)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_w    = shift_q[DATA_W-1];
      assign shifted_w = {shift_q[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_w    = shift_q[0];
      assign shifted_w = {1'b0, shift_q[DATA_W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    div_d     = div_q;
    buf_pop   = 1'b0;
    buf_clear = 1'b0;
    done_w    = 1'b0;
    under_w   = 1'b0;
    if (!enable) begin
      // Abort: drop the word in flight and anything buffered, no status pulses.
      state_d   = S_IDLE;
      shift_d   = '0;
      bit_d     = '0;
      div_d     = '0;
      buf_clear = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_d = '0;
          div_d = '0;
          if (buf_full) begin
            buf_pop = 1'b1;
            shift_d = buf_data;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_q == C_DIV_LAST) begin
            div_d = '0;
            if (bit_q == C_BIT_LAST) begin
              done_w = 1'b1;
              bit_d  = '0;
              // Reload on the same edge so the next word follows with no gap.
              if (buf_full) begin
                buf_pop = 1'b1;
                shift_d = buf_data;
              end else begin
                under_w = 1'b1;
                shift_d = '0;
                state_d = S_IDLE;
              end
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = shifted_w;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          shift_d = '0;
          bit_d   = '0;
          div_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  assign word_done  = reset_n & done_w;
  assign underrun   = reset_n & under_w;
  assign audio_data = reset_n & (state_q == S_SHIFT) & head_w;

`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != {UNDERRUN_CNT_W{1'b1}})) begin
      ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_serializer_p.sv
// ---------------------------------------------------------------------------
// tb_audio_serializer_p : directed self-checking bench for audio_serializer_p
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_audio_serializer_p;

  logic        clock;
  logic        reset_n;
  logic        en0, v0, rdy0, ae0, ad0, wd0, ur0;
  logic [15:0] d0;
  logic        en1, v1, rdy1, ae1, ad1, wd1, ur1;
  logic [15:0] d1;
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
  logic [15:0] uc0, uc1;
`endif

  int n_checks;
  int n_errors;

  audio_serializer_p #(.DATA_W(16), .BIT_DIV(1), .MSB_FIRST(1'b1)) u_dut0 (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (en0),
    .in_valid     (v0),
    .in_ready     (rdy0),
    .in_data      (d0),
    .audio_enable (ae0),
    .audio_data   (ad0),
    .word_done    (wd0),
    .underrun     (ur0)
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    ,
    .underrun_count (uc0)
`endif
  );

  audio_serializer_p #(.DATA_W(16), .BIT_DIV(4), .MSB_FIRST(1'b0)) u_dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (en1),
    .in_valid     (v1),
    .in_ready     (rdy1),
    .in_data      (d1),
    .audio_enable (ae1),
    .audio_data   (ad1),
    .word_done    (wd1),
    .underrun     (ur1)
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    ,
    .underrun_count (uc1)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called 1ns after an edge with dut0 idle and its buffer empty.
  task automatic send_word0(input logic [15:0] d);
    v0 = 1'b1;
    d0 = d;
    #1;
    check_value("rdy_idle", {31'b0, rdy0}, 32'd1);
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) begin
        check_value("rdy_full", {31'b0, rdy0}, 32'd0);
        v0 = 1'b0;
      end
      if (c >= 2 && c <= 17)
        check_value("word_bit", {29'b0, ad0, wd0, ur0}, {29'b0, d[17-c], c == 17, c == 17});
      else
        check_value("word_idle", {29'b0, ad0, wd0, ur0}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    en0 = 1'b0; v0 = 1'b0; d0 = 16'h0000;
    en1 = 1'b0; v1 = 1'b0; d1 = 16'h0000;

    // Reset state, including in_ready held low even with enable high
    tick();
    tick();
    en0 = 1'b1;
    en1 = 1'b1;
    #1;
    check_value("rst_dut0", {28'b0, ad0, wd0, ur0, rdy0}, 32'd0);
    check_value("rst_dut1", {28'b0, ad1, wd1, ur1, rdy1}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_value("rdy_after_rst", {30'b0, rdy0, rdy1}, 32'd3);
    check_value("audio_enable", {30'b0, ae0, ae1}, 32'd3);

    // Single word, MSB first, underrun on the last bit
    send_word0(16'hA5C3);

    // Back-to-back FFFF then 0000 with zero gap
    v0 = 1'b1;
    d0 = 16'hFFFF;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) begin
        check_value("b2b_rdy_full", {31'b0, rdy0}, 32'd0);
        d0 = 16'h0000;
      end
      if (c == 2)  check_value("b2b_rdy_drained", {31'b0, rdy0}, 32'd1);
      if (c == 3)  v0 = 1'b0;
      if (c == 17) check_value("b2b_no_passthru", {31'b0, rdy0}, 32'd0);
      check_value("b2b_stream", {29'b0, ad0, wd0, ur0},
                  {29'b0, (c >= 2 && c <= 17), (c == 17 || c == 33), (c == 33)});
    end

    // BIT_DIV=4, LSB first, 0001
    v1 = 1'b1;
    d1 = 16'h0001;
    for (int c = 1; c <= 66; c++) begin
      tick();
      if (c == 1) v1 = 1'b0;
      check_value("div4_stream", {29'b0, ad1, wd1, ur1},
                  {29'b0, (c >= 2 && c <= 5), (c == 65), (c == 65)});
    end

    // Enable dropped at bit 7 with the buffer full
    v0 = 1'b1;
    d0 = 16'hFFFF;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) d0 = 16'h00FF;
      if (c == 3) begin
        v0 = 1'b0;
        check_value("abort_buf_full", {31'b0, rdy0}, 32'd0);
      end
    end
    check_value("abort_bit7", {31'b0, ad0}, 32'd1);
    en0 = 1'b0;
    #1;
    check_value("abort_now", {28'b0, ae0, wd0, ur0, rdy0}, 32'd0);
    for (int c = 10; c <= 11; c++) begin
      tick();
      check_value("abort_idle", {29'b0, ad0, wd0, ur0, rdy0}, 32'd0);
    end
    en0 = 1'b1;
    send_word0(16'h8000);
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    check_value("ucnt_three", {16'b0, uc0}, 32'd3);
`endif

    // Reset pulsed mid-word
    v0 = 1'b1;
    d0 = 16'hFFFF;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) v0 = 1'b0;
    end
    check_value("rst_mid_bit", {31'b0, ad0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_value("rst_mid_now", {29'b0, ad0, wd0, ur0, rdy0}, 32'd0);
    tick();
    check_value("rst_mid_after", {29'b0, ad0, wd0, ur0, rdy0}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_value("rst_mid_rdy", {31'b0, rdy0}, 32'd1);
    for (int c = 9; c <= 12; c++) begin
      tick();
      check_value("rst_mid_quiet", {29'b0, ad0, wd0, ur0}, 32'd0);
    end
`ifdef AUDIO_SERIALIZER_UNDERRUN_CNT_EN
    check_value("ucnt_rst", {16'b0, uc0}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
